// File: rtl/edge_pkg.sv
// Shared definitions for the Sobel edge stream packer.
//   WORD_W / FIFO_DEPTH : packed word width and output buffer depth
//   EDGE_CODE           : detector output value meaning "edge"
//   state_t             : packer frame-tracking states
//   fifo_entry_t        : one buffered output word with its tags
//   sat_inc()           : saturating increment shared by the counters
package edge_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam logic [9:0]  EDGE_CODE  = 10'd0;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              sof;
        logic              eol;
    } fifo_entry_t;

    // Callers cast in/out of 32 bits; max_value is the counter's all-ones value.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/dval_delay.sv
// Pixel-valid realignment delay line.
//   clk_i  : clock
//   rst_i  : asynchronous active-high clear
//   dval_i : pixel-valid strobe at the detector input
//   dval_o : strobe delayed LAT cycles (LAT = 0 is a pass-through)
module dval_delay #(
    parameter int unsigned LAT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic dval_i,
    output logic dval_o
);

    if (LAT == 0) begin : g_bypass
        assign dval_o = dval_i;
    end else begin : g_shift
        logic [LAT-1:0] sr_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sr_q <= '0;
            end else begin
                sr_q[0] <= dval_i;
                for (int i = 1; i < int'(LAT); i++) begin
                    sr_q[i] <= sr_q[i-1];
                end
            end
        end

        assign dval_o = sr_q[LAT-1];
    end

endmodule

// File: rtl/edge_stream_packer.sv
// Consumer end of the Sobel edge stream: realigns the pixel strobe to the
// detector latency, tracks raster position and packs one edge bit per pixel
// into 16-bit words, LSB = lowest column, delivered over ready/valid.
//   CLOCK, RESET  : clock, asynchronous active-high reset
//   iDVAL         : pixel strobe as seen at the detector input
//   edge_data     : thresholded detector output (0 = edge)
//   oDATA/oVALID  : packed word and its valid, accepted with iREADY
//   oSOF / oEOL   : first word of frame / last word of line
//   frame_done    : one-cycle pulse after a frame's last pixel is packed
//   overflow_cnt  : saturating count of words dropped on a full buffer
// Optional: define EDGE_COUNT_EN to add edge_count, the number of edge
// pixels in the last completed frame.
module edge_stream_packer
    import edge_pkg::*;
#(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned LAT   = 4
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        iDVAL,
    input  logic [9:0]  edge_data,
    output logic [15:0] oDATA,
    output logic        oVALID,
    input  logic        iREADY,
    output logic        oSOF,
    output logic        oEOL,
    output logic        frame_done,
    output logic [15:0] overflow_cnt
`ifdef EDGE_COUNT_EN
    ,
    output logic [19:0] edge_count
`endif
);

    localparam logic [11:0] COL_LAST = 12'(IMG_W - 1);
    localparam logic [11:0] ROW_LAST = 12'(IMG_H - 1);

    logic pix_v;
    logic edge_bit;

    dval_delay #(
        .LAT(LAT)
    ) u_dval_delay (
        .clk_i (CLOCK),
        .rst_i (RESET),
        .dval_i(iDVAL),
        .dval_o(pix_v)
    );

    assign edge_bit = (edge_data == EDGE_CODE);

    // ------------------------------------------------------------------
    // Frame FSM and raster position
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [11:0]       col_q, col_d;
    logic [11:0]       row_q, row_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              sof_pend_q, sof_pend_d;

    logic              new_frame;
    logic [11:0]       cur_col;
    logic [11:0]       cur_row;
    logic              last_col;
    logic              last_row;
    logic              frame_end;
    logic [3:0]        bit_idx;
    logic              sof_eff;
    logic              word_emit;
    logic [WORD_W-1:0] new_word;

    // Any pixel seen outside ACTIVE opens a new frame at (0,0).
    assign new_frame = (state_q != ACTIVE);
    assign cur_col   = new_frame ? 12'd0 : col_q;
    assign cur_row   = new_frame ? 12'd0 : row_q;
    assign last_col  = (cur_col == COL_LAST);
    assign last_row  = (cur_row == ROW_LAST);
    assign frame_end = pix_v && last_col && last_row;
    assign bit_idx   = cur_col[3:0];
    assign sof_eff   = sof_pend_q || new_frame;
    assign word_emit = pix_v && ((bit_idx == 4'hF) || last_col);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACTIVE: begin
                if (pix_v) state_d = frame_end ? DONE : ACTIVE;
            end
            DONE: begin
                if (pix_v) state_d = frame_end ? DONE : ACTIVE;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output buffer (2 entries)
    // ------------------------------------------------------------------
    fifo_entry_t fifo_q [FIFO_DEPTH];
    fifo_entry_t push_entry;
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        pop;
    logic        full;
    logic        push_ok;
    logic        drop;
    logic [15:0] overflow_q, overflow_d;

    assign pop     = oVALID && iREADY;
    assign full    = (count_q == 2'(FIFO_DEPTH));
    // A full buffer still accepts when the head leaves in the same cycle.
    assign push_ok = word_emit && (!full || pop);
    assign drop    = word_emit && full && !pop;
    assign count_d = count_q + {1'b0, push_ok} - {1'b0, pop};

    assign push_entry.data = new_word;
    assign push_entry.sof  = sof_eff;
    assign push_entry.eol  = last_col;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        word_d     = word_q;
        sof_pend_d = sof_pend_q;
        // Column 0 of each word clears stale bits, so partial words pad with 0.
        new_word          = (bit_idx == 4'd0) ? '0 : word_q;
        new_word[bit_idx] = edge_bit;
        if (pix_v) begin
            word_d = new_word;
            if (last_col) begin
                col_d = 12'd0;
                row_d = last_row ? 12'd0 : cur_row + 12'd1;
            end else begin
                col_d = cur_col + 12'd1;
                row_d = cur_row;
            end
            // SOF stays pending if its word was dropped.
            sof_pend_d = word_emit ? (sof_eff && !push_ok) : sof_eff;
        end
    end

    assign overflow_d = drop ? 16'(sat_inc(32'(overflow_q), 32'h0000_FFFF)) : overflow_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            word_q     <= '0;
            sof_pend_q <= 1'b0;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            word_q     <= word_d;
            sof_pend_q <= sof_pend_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                fifo_q[wr_ptr_q] <= push_entry;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign oVALID       = (count_q != 2'd0);
    assign oDATA        = fifo_q[rd_ptr_q].data;
    assign oSOF         = fifo_q[rd_ptr_q].sof;
    assign oEOL         = fifo_q[rd_ptr_q].eol;
    assign frame_done   = (state_q == DONE);
    assign overflow_cnt = overflow_q;

`ifdef EDGE_COUNT_EN
    // ------------------------------------------------------------------
    // Per-frame edge pixel count
    // ------------------------------------------------------------------
    logic [19:0] acc_q, acc_d;
    logic [19:0] edge_count_q, edge_count_d;
    logic [19:0] acc_inc;

    always_comb begin
        acc_d        = acc_q;
        edge_count_d = edge_count_q;
        acc_inc      = edge_bit ? 20'(sat_inc(32'(acc_q), 32'h000F_FFFF)) : acc_q;
        if (pix_v) begin
            // Load on the last pixel so edge_count is valid while frame_done is high.
            if (frame_end) begin
                edge_count_d = acc_inc;
                acc_d        = '0;
            end else begin
                acc_d = acc_inc;
            end
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            acc_q        <= '0;
            edge_count_q <= '0;
        end else begin
            acc_q        <= acc_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign edge_count = edge_count_q;
`endif

endmodule

// File: doc/edge_stream_packer.md
Name: edge_stream_packer

Overview:
- Consumer end of the Sobel edge stream: takes the per-pixel thresholded edge output (10-bit, 0 = edge, 0x3FF = no edge) and the pixel-valid strobe.
- Realigns the strobe to the detector's pipeline latency, tracks raster position, and packs edge bits into 16-bit words.
- Presents words on a ready/valid interface to the SDRAM write FIFO feeding the VGA/display path.

Parameters:
- IMG_W, 640, active pixels per line (1..4095)
- IMG_H, 480, lines per frame (1..4095)
- LAT, 4, cycles from iDVAL at the detector input to the matching edge_data sample (0..15)

Ports:
- CLOCK  in  1  single clock for all logic
- RESET  in  1  asynchronous, active-high reset
- iDVAL  in  1  pixel-valid strobe, as presented to the edge detector input
- edge_data  in  10  thresholded detector output
- oDATA  out  16  packed edge word; bit n = pixel (word_base+n); 1 = edge
- oVALID  out  1  oDATA valid
- iREADY  in  1  downstream accepts word when oVALID && iREADY
- oSOF  out  1  qualifies oDATA: first word of frame
- oEOL  out  1  qualifies oDATA: last word of a line
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is packed
- overflow_cnt  out  16  saturating count of dropped words

Behaviour:
- Reset (async, RESET=1): all outputs 0, counters 0, output buffer empty, FSM in IDLE, delay line cleared.
- Delay: pix_v = iDVAL delayed LAT cycles through a shift register; LAT=0 means pass-through. edge_bit = (edge_data == 10'd0).
- FSM states:
  - IDLE: first pix_v sample goes to ACTIVE, that pixel is col 0 / row 0, and sof_pend is set.
  - ACTIVE: packs pixels while pix_v.
  - DONE: entered after pixel (IMG_W-1, IMG_H-1) is packed. Asserts frame_done for exactly one cycle, then goes to IDLE.
- Packing:
  - Bit index = col mod 16, LSB first.
  - A word is emitted when bit 15 is filled, or on col == IMG_W-1. A partial last word has its unfilled upper bits 0.
  - Word tags: oEOL=1 when it ends a line; oSOF=1 on the first word emitted while sof_pend, which then clears.
  - col wraps to 0 at IMG_W-1 and row increments; row wraps at IMG_H-1 on entry to DONE.
- Gaps: pix_v low holds all state; no timeout.
- Output buffer: 2-entry FIFO holding {oDATA, oSOF, oEOL}; oVALID = not empty.
  - Latency: a word is on oDATA one cycle after its completing pixel is sampled, when the buffer was empty.
  - Push and pop in the same cycle while full: both occur, no drop.
  - Push while full with no pop: the word is discarded, overflow_cnt += 1, saturating at 0xFFFF. Packing continues and the position counters are unaffected. A discarded word carrying oSOF sets sof_pend again.
  - The held head word and its tags are stable while oVALID && !iREADY.
- overflow_cnt clears only on reset.
- pix_v asserted during DONE is packed as col 0 / row 0 of the next frame, with sof_pend set.
- Reset mid-frame: the partial word and buffered words are lost; the next frame restarts from IDLE.

Optional Feature:
- EDGE_COUNT_EN defined:
  - Adds output edge_count [19:0]: the number of edge_bit=1 pixels in the last completed frame.
  - The internal accumulator updates when the frame's last pixel is sampled. edge_count is loaded, and the accumulator cleared, on the cycle frame_done asserts.
  - edge_count is 0 after reset; the accumulator saturates at 0xFFFFF.
- EDGE_COUNT_EN undefined: the port and the accumulator are absent; all other behaviour is identical.

Decomposition:
- Package edge_pkg holds:
  - WORD_W=16 and FIFO_DEPTH=2
  - EDGE_CODE=10'd0
  - the state enum {IDLE, ACTIVE, DONE}
  - the saturating-increment function used by overflow_cnt and edge_count
- One sub-module, dval_delay, parameterised by LAT: shift register with async active-high clear.
- The FIFO is kept inline.

Test Plan:
- LAT=4, IMG_W=20, IMG_H=2, iREADY=1; pixels 0,3,17 are edges on row 0, and all of row 1 are non-edges -> four words:
  - 0x0009 with oSOF=1, oEOL=0
  - 0x0002 with oEOL=1
  - 0x0000, then 0x0000 with oEOL=1
  - frame_done pulses once, one cycle after the last pixel is packed.
- Same frame with iDVAL low on alternate cycles -> identical word sequence and tags.
- iREADY=0 for the whole frame, 4 words produced -> first two words held stable, overflow_cnt=2; then iREADY=1 pops 0x0009 and 0x0002 in order.
- Saturation: force 70000 drops -> overflow_cnt=0xFFFF; RESET pulse -> 0.
- RESET asserted after 10 pixels of a frame, then a full frame sent -> first word out carries oSOF=1 and reflects only the new frame's bits.
- With EDGE_COUNT_EN defined: 20x2 frame containing 7 edges -> edge_count=7 on the cycle frame_done asserts; next frame with 0 edges -> edge_count=0.
